sprite_line_renderer: RTL and testbench

- Pixel-clock consumer of the sprite register/bitmap RAM loader.
- Captures the six per-frame sprite register words as the loader strobes them.
- During each horizontal blank, fetches the next line's 16-bit bitmap row from sprite RAM by driving sprite_addr.
- During active video, outputs a registered 1bpp sprite pixel and its colour for the VGA mixer.

---
 rtl/sprite_line_renderer.sv | 136 +++++++++++++
 tb/tb_sprite_line_renderer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: captures sprite registers, fetches the next line's bitmap row during hblank,
// and emits a registered 1bpp pixel plus colour. Define SPRITE_MIRROR_EN to honour ctrl bit1 (horizontal mirror).
module sprite_line_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic        px_clk,
    input  logic        rst,
    input  logic [15:0] reg_data,
    input  logic [5:0]  en,
    input  logic        loading_loc,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    output logic [8:0]  sprite_addr,
    output logic        pixel_on,
    output logic [7:0]  pixel_color
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
`ifdef SPRITE_MIRROR_EN
    localparam bit MIRROR_EN = 1'b1;
`else
    localparam bit MIRROR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;
    state_t state_q, state_d;

    logic [9:0]  xpos_q, ypos_q;
    logic [1:0]  ctrl_q;
    logic [8:0]  base_q;
    logic [7:0]  color_q;
    logic [4:0]  height_q;
    logic [15:0] cur_line_q, next_line_q, next_line_d;
    logic        cur_valid_q, next_valid_q, next_valid_d;
    logic [8:0]  sprite_addr_q, sprite_addr_d;
    logic        pixel_on_q, pixel_on_d;
    logic [7:0]  pixel_color_q, pixel_color_d;

    logic [9:0] nl, row, col;
    logic [4:0] eff_h;
    logic [3:0] idx;
    logic       in_range, at_start, fetch_go, busy, abort, retry;

    // Rows wrap around the frame so a sprite near the bottom continues on line 0.
    assign nl       = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
    assign row      = (nl >= ypos_q) ? nl - ypos_q : nl + V_TOT - ypos_q;
    assign eff_h    = (height_q == 5'd0 || height_q > 5'd16) ? 5'd16 : height_q;
    assign in_range = row < {5'd0, eff_h};
    assign at_start = (h_count == H_ACT);
    assign fetch_go = at_start && ctrl_q[0] && in_range;
    assign busy     = (state_q != IDLE);
    assign abort    = busy && (h_count == H_LAST);
    assign retry    = busy && !abort && loading_loc;

    always_ff @(posedge px_clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fetch_go) state_d = ADDR;
            ADDR: state_d = WAIT;
            WAIT: state_d = DATA;
            DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort)      state_d = IDLE;
        else if (retry) state_d = ADDR;
    end

    always_comb begin
        sprite_addr_d = sprite_addr_q;
        next_line_d   = next_line_q;
        next_valid_d  = next_valid_q;
        // A new fetch window invalidates the staged row until it is actually latched.
        if (state_q == IDLE && at_start) begin
            next_valid_d = 1'b0;
            if (fetch_go) sprite_addr_d = base_q + {5'd0, row[3:0]};
        end
        if (abort) begin
            next_valid_d = 1'b0;
        end else if (state_q == DATA && !loading_loc) begin
            next_line_d  = reg_data;
            next_valid_d = 1'b1;
        end
    end

    assign col        = h_count - xpos_q;
    assign idx        = (MIRROR_EN && ctrl_q[1]) ? col[3:0] : ~col[3:0];
    assign pixel_on_d = cur_valid_q & ctrl_q[0] & (col < 10'd16) & (h_count < H_ACT) & cur_line_q[idx];
    assign pixel_color_d = pixel_on_d ? color_q : 8'd0;

    always_ff @(posedge px_clk) begin
        if (rst) begin
            xpos_q        <= '0;
            ypos_q        <= '0;
            ctrl_q        <= '0;
            base_q        <= '0;
            color_q       <= '0;
            height_q      <= '0;
            cur_line_q    <= '0;
            cur_valid_q   <= 1'b0;
            next_line_q   <= '0;
            next_valid_q  <= 1'b0;
            sprite_addr_q <= '0;
            pixel_on_q    <= 1'b0;
            pixel_color_q <= '0;
        end else begin
            if (en[0])      xpos_q   <= reg_data[9:0];
            else if (en[1]) ypos_q   <= reg_data[9:0];
            else if (en[2]) ctrl_q   <= reg_data[1:0];
            else if (en[3]) base_q   <= reg_data[8:0];
            else if (en[4]) color_q  <= reg_data[7:0];
            else if (en[5]) height_q <= reg_data[4:0];
            next_line_q   <= next_line_d;
            next_valid_q  <= next_valid_d;
            if (h_count == H_LAST) begin
                cur_line_q  <= next_line_q;
                cur_valid_q <= next_valid_q;
            end
            sprite_addr_q <= sprite_addr_d;
            pixel_on_q    <= pixel_on_d;
            pixel_color_q <= pixel_color_d;
        end
    end

    assign sprite_addr = sprite_addr_q;
    assign pixel_on    = pixel_on_q;
    assign pixel_color = pixel_color_q;
endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer: drives h/v counters, a registered sprite RAM model and register strobes.
module tb_sprite_line_renderer;
    logic        px_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reg_data;
    logic [5:0]  en = '0;
    logic        loading_loc = 1'b0;
    logic [9:0]  h_count = '0, v_count = '0;
    logic [8:0]  sprite_addr;
    logic        pixel_on;
    logic [7:0]  pixel_color;

    logic        ld_en = 1'b0;
    logic [15:0] ld_data = '0, ram_q = '0;
    logic [15:0] ram [0:511];
    int          checks = 0, errors = 0;
    logic [799:0] on_map;
    int          ons, bad_color;
    logic [8:0]  addr641;
    logic [7:0]  col100;
    int          lo_s = 1000, lo_e = 1000;

    sprite_line_renderer dut (
        .px_clk(px_clk), .rst(rst), .reg_data(reg_data), .en(en), .loading_loc(loading_loc),
        .h_count(h_count), .v_count(v_count), .sprite_addr(sprite_addr),
        .pixel_on(pixel_on), .pixel_color(pixel_color)
    );

    always #5 px_clk = ~px_clk;

    // Port B: one-cycle read latency; loader traffic shows up as junk while it owns the port.
    assign reg_data = ld_en ? ld_data : ram_q;
    always @(posedge px_clk) ram_q <= loading_loc ? 16'hFFFF : ram[sprite_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int v, input int h);
        v_count = 10'(v);
        h_count = 10'(h);
        loading_loc = (h >= lo_s && h <= lo_e);
        @(posedge px_clk);
        #1;
        on_map[h] = pixel_on;
        if (pixel_on) ons++;
        if (!pixel_on && pixel_color != 8'd0) bad_color++;
        if (h == 641) addr641 = sprite_addr;
        if (h == 100) col100 = pixel_color;
    endtask

    task automatic run_line(input int v, input int h0, input int h1);
        on_map = '0;
        ons = 0;
        for (int h = h0; h <= h1; h++) cyc(v, h);
        loading_loc = 1'b0;
    endtask

    task automatic wr(input logic [5:0] e, input logic [15:0] d);
        en = e; ld_en = 1'b1; ld_data = d;
        v_count = 10'd0; h_count = 10'd10; loading_loc = 1'b0;
        @(posedge px_clk);
        #1;
        en = '0; ld_en = 1'b0;
    endtask

    task automatic wrk(input int k, input logic [15:0] d);
        wr(6'(1 << k), d);
    endtask

    task automatic load_t2();
        wrk(0, 16'd100); wrk(1, 16'd50); wrk(2, 16'h0001);
        wrk(3, 16'h0010); wrk(4, 16'h002A); wrk(5, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
        ram[16] = 16'hC001;
        repeat (2) @(posedge px_clk);
        #1;
        chk("rst_addr", 32'(sprite_addr), 32'd0);
        chk("rst_on", 32'(pixel_on), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a fetch
        load_t2();
        for (int h = 638; h <= 641; h++) cyc(49, h);
        chk("t1_fetch_addr", 32'(sprite_addr), 32'h10);
        rst = 1'b1;
        cyc(49, 642);
        rst = 1'b0;
        chk("t1_rst_addr", 32'(sprite_addr), 32'd0);
        chk("t1_rst_on", 32'(pixel_on), 32'd0);
        chk("t1_rst_color", 32'(pixel_color), 32'd0);
        run_line(49, 0, 799);
        chk("t1_no_fetch", 32'(addr641), 32'd0);
        run_line(50, 0, 799);
        chk("t1_blank", 32'(ons), 32'd0);

        // Register load and draw
        load_t2();
        bad_color = 0;
        run_line(49, 0, 799);
        chk("t2_addr", 32'(addr641), 32'h10);
        run_line(50, 0, 799);
        chk("t2_ons", 32'(ons), 32'd3);
        chk("t2_px100", 32'(on_map[100]), 32'd1);
        chk("t2_px101", 32'(on_map[101]), 32'd1);
        chk("t2_px102", 32'(on_map[102]), 32'd0);
        chk("t2_px114", 32'(on_map[114]), 32'd0);
        chk("t2_px115", 32'(on_map[115]), 32'd1);
        chk("t2_color", 32'(col100), 32'h2A);
        chk("t2_color_off", 32'(bad_color), 32'd0);

        // Height 4: lines 50..53 only
        ram[16] = 16'h8000; ram[17] = 16'h4000; ram[18] = 16'h2000; ram[19] = 16'h1000;
        wrk(5, 16'd4);
        for (int v = 49; v <= 54; v++) begin
            run_line(v, 0, 799);
            if (v <= 52) chk($sformatf("t3_addr_l%0d", v), 32'(addr641), 32'(16 + v - 49));
            if (v == 53) chk("t3_addr_hold", 32'(addr641), 32'd19);
            if (v >= 50 && v <= 53) begin
                chk($sformatf("t3_ons_l%0d", v), 32'(ons), 32'd1);
                chk($sformatf("t3_px_l%0d", v), 32'(on_map[100 + v - 50]), 32'd1);
            end
            if (v == 54) chk("t3_l54_blank", 32'(ons), 32'd0);
        end

        // Vertical wrap with ypos = 524
        wrk(1, 16'd524);
        run_line(523, 0, 799);
        chk("t3_wrap_addr523", 32'(addr641), 32'd16);
        run_line(524, 0, 799);
        chk("t3_wrap_addr524", 32'(addr641), 32'd17);
        chk("t3_l524_px100", 32'(on_map[100]), 32'd1);
        run_line(0, 0, 799);
        chk("t3_l0_ons", 32'(ons), 32'd1);
        chk("t3_l0_px101", 32'(on_map[101]), 32'd1);

        // Arbitration: retry, then hold-off to end of line
        wrk(1, 16'd50);
        lo_s = 641; lo_e = 645;
        run_line(49, 0, 799);
        chk("t4_retry_addr", 32'(addr641), 32'd16);
        lo_s = 641; lo_e = 799;
        run_line(50, 0, 799);
        chk("t4_retry_ons", 32'(ons), 32'd1);
        chk("t4_retry_px100", 32'(on_map[100]), 32'd1);
        lo_s = 1000; lo_e = 1000;
        run_line(51, 0, 799);
        chk("t4_abort_blank", 32'(ons), 32'd0);

        // Clipping at H_ACTIVE
        ram[16] = 16'hFFFF;
        wrk(0, 16'd630);
        run_line(49, 0, 799);
        run_line(50, 0, 799);
        chk("t5_ons", 32'(ons), 32'd10);
        chk("t5_px629", 32'(on_map[629]), 32'd0);
        chk("t5_px630", 32'(on_map[630]), 32'd1);
        chk("t5_px639", 32'(on_map[639]), 32'd1);
        chk("t5_px640", 32'(on_map[640]), 32'd0);
        run_line(51, 0, 5);
        chk("t5_nowrap", 32'(ons), 32'd0);

        // Mirror; xpos set through a two-bit strobe (lowest index wins, ypos untouched)
        ram[16] = 16'h8000;
        wr(6'b000011, 16'd100);
        wrk(2, 16'h0003);
        run_line(49, 0, 799);
        chk("t6_addr", 32'(addr641), 32'd16);
        run_line(50, 0, 799);
        chk("t6_ons", 32'(ons), 32'd1);
`ifdef SPRITE_MIRROR_EN
        chk("t6_mirror_px", 32'(on_map[115]), 32'd1);
`else
        chk("t6_plain_px", 32'(on_map[100]), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
